// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl
//   Places one food item on the GRID_W x GRID_H playfield. A spawn request
//   draws random candidates from the external x/y generator and checks each
//   one against the occupancy map. Out-of-range or occupied candidates count
//   as failed tries. After MAX_TRIES failures the block scans the board in
//   row-major order and takes the first free cell. If the whole board is
//   occupied it reports failure.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   spawn_req           single-cycle placement request (ignored while busy)
//   clear_food          food eaten; drops food_valid on the next edge
//   rnd_x, rnd_y        random coordinate from the generator
//   lfsr_step           one-cycle pulse that advances the generator
//   query_valid         query_x/query_y are being presented to the map
//   query_x, query_y    cell under test
//   query_occupied      map answer, valid QUERY_LAT cycles after presentation
//   food_x, food_y      placed food cell
//   food_valid          food currently on the board
//   busy                placement in progress
//   done                one-cycle pulse on successful placement
//   fail                one-cycle pulse when no free cell exists
module food_spawn_ctrl #(
  parameter int unsigned GRID_W    = 10,
  parameter int unsigned GRID_H    = 10,
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned QUERY_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn_req,
  input  logic       clear_food,
  input  logic [3:0] rnd_x,
  input  logic [3:0] rnd_y,
  output logic       lfsr_step,
  output logic       query_valid,
  output logic [3:0] query_x,
  output logic [3:0] query_y,
  input  logic       query_occupied,
  output logic [3:0] food_x,
  output logic [3:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_QUERY  = 3'd2;
  localparam logic [2:0] S_PLACE  = 3'd3;
  localparam logic [2:0] S_SCAN   = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [3:0] X_LAST    = 4'(GRID_W - 1);
  localparam logic [3:0] Y_LAST    = 4'(GRID_H - 1);
  localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);
  localparam logic [1:0] LAT_LAST  = 2'(QUERY_LAT);

  logic [2:0] state_q, state_d;
  logic [3:0] tries_q, tries_d;
  logic [1:0] lat_q, lat_d;
  logic [3:0] cand_x_q, cand_x_d;
  logic [3:0] cand_y_q, cand_y_d;
  logic [3:0] food_x_q, food_x_d;
  logic [3:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;

  logic       place_go;
  logic       failed_try;
  logic       ans_valid;
  logic       cand_last;
  logic [3:0] tries_inc;

  // The map answer for the presented cell is sampled on the final hold cycle.
  assign ans_valid = (lat_q == LAT_LAST);
  assign cand_last = (cand_x_q == X_LAST) && (cand_y_q == Y_LAST);
  assign tries_inc = tries_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    lat_d      = lat_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    lfsr_step  = 1'b0;
    place_go   = 1'b0;
    failed_try = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (spawn_req) begin
          state_d   = S_SAMPLE;
          tries_d   = '0;
          lfsr_step = 1'b1;
        end
      end

      S_SAMPLE: begin
        cand_x_d = rnd_x;
        cand_y_d = rnd_y;
        lat_d    = '0;
        if ((rnd_x > X_LAST) || (rnd_y > Y_LAST)) begin
          failed_try = 1'b1;
        end else begin
          state_d = S_QUERY;
        end
      end

      S_QUERY: begin
        if (ans_valid) begin
          if (!query_occupied) begin
            state_d  = S_PLACE;
            place_go = 1'b1;
          end else begin
            failed_try = 1'b1;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      S_SCAN: begin
        if (ans_valid) begin
          lat_d = '0;
          if (!query_occupied) begin
            state_d  = S_PLACE;
            place_go = 1'b1;
          end else if (cand_last) begin
            state_d = S_FAIL;
          end else if (cand_x_q == X_LAST) begin
            cand_x_d = '0;
            cand_y_d = cand_y_q + 4'd1;
          end else begin
            cand_x_d = cand_x_q + 4'd1;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      S_PLACE: state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (failed_try) begin
      tries_d = tries_inc;
      if (tries_inc == TRY_LIMIT) begin
        state_d  = S_SCAN;
        cand_x_d = '0;
        cand_y_d = '0;
        lat_d    = '0;
      end else begin
        state_d   = S_SAMPLE;
        lfsr_step = 1'b1;
      end
    end
  end

  // Food registers load on entry to PLACE so the new position and food_valid
  // are visible in the same cycle as the done pulse; clear_food is overridden
  // both on that entry edge and during PLACE itself.
  always_comb begin
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    if (clear_food) begin
      food_valid_d = 1'b0;
    end
    if (place_go) begin
      food_x_d     = cand_x_q;
      food_y_d     = cand_y_q;
      food_valid_d = 1'b1;
    end else if (state_q == S_PLACE) begin
      food_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tries_q      <= '0;
      lat_q        <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      lat_q        <= lat_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
    end
  end

  assign query_valid = (state_q == S_QUERY) || (state_q == S_SCAN);
  assign query_x     = cand_x_q;
  assign query_y     = cand_y_q;
  assign food_x      = food_x_q;
  assign food_y      = food_y_q;
  assign food_valid  = food_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_PLACE);
  assign fail        = (state_q == S_FAIL);

endmodule

// File: tb/tb_food_spawn_ctrl.sv
module tb_food_spawn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       spawn_req;
  logic       clear_food;
  logic [3:0] rnd_x, rnd_y;
  logic       lfsr_step;
  logic       query_valid;
  logic [3:0] query_x, query_y;
  logic       query_occupied;
  logic [3:0] food_x, food_y;
  logic       food_valid, busy, done, fail;

  always #5 clk = ~clk;

  food_spawn_ctrl #(
    .GRID_W(10),
    .GRID_H(10),
    .MAX_TRIES(8),
    .QUERY_LAT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spawn_req(spawn_req),
    .clear_food(clear_food),
    .rnd_x(rnd_x),
    .rnd_y(rnd_y),
    .lfsr_step(lfsr_step),
    .query_valid(query_valid),
    .query_x(query_x),
    .query_y(query_y),
    .query_occupied(query_occupied),
    .food_x(food_x),
    .food_y(food_y),
    .food_valid(food_valid),
    .busy(busy),
    .done(done),
    .fail(fail)
  );

  // Environment models: occupancy map with one-cycle answer latency, a
  // scripted random sequence advanced by lfsr_step, and event counters.
  bit         occ_map [16][16];
  logic [3:0] rnd_xs [32];
  logic [3:0] rnd_ys [32];
  logic [4:0] rnd_idx;
  logic       mon_clr;
  logic       occ_r;
  int         lfsr_cnt, done_cnt, fail_cnt, qv_cycles, log_n;
  logic [3:0] log_x [256];
  logic [3:0] log_y [256];
  logic       qv_prev;
  logic [3:0] px, py;

  assign rnd_x          = rnd_xs[rnd_idx];
  assign rnd_y          = rnd_ys[rnd_idx];
  assign query_occupied = occ_r;

  always @(posedge clk) begin
    occ_r <= occ_map[query_x][query_y];
    if (mon_clr) begin
      rnd_idx   <= '0;
      lfsr_cnt  <= 0;
      done_cnt  <= 0;
      fail_cnt  <= 0;
      qv_cycles <= 0;
      log_n     <= 0;
      qv_prev   <= 1'b0;
      px        <= '0;
      py        <= '0;
    end else begin
      if (lfsr_step) begin
        rnd_idx  <= rnd_idx + 5'd1;
        lfsr_cnt <= lfsr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (fail) fail_cnt <= fail_cnt + 1;
      if (query_valid) begin
        qv_cycles <= qv_cycles + 1;
        if (!qv_prev || query_x != px || query_y != py) begin
          if (log_n < 256) begin
            log_x[log_n[7:0]] <= query_x;
            log_y[log_n[7:0]] <= query_y;
          end
          log_n <= log_n + 1;
        end
      end
      qv_prev <= query_valid;
      px      <= query_x;
      py      <= query_y;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_board(input bit v);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        occ_map[x][y] = v;
  endtask

  task automatic set_rnd(input logic [3:0] x, input logic [3:0] y);
    for (int i = 0; i < 32; i++) begin
      rnd_xs[i] = x;
      rnd_ys[i] = y;
    end
  endtask

  task automatic clr_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Called at the negedge where spawn_req was raised (cycle 0); returns the
  // cycle index in which done or fail is seen, or -1 on budget expiry.
  task automatic wait_end(input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      spawn_req = 1'b0;
      #1;
      if (done || fail) begin
        cyc = k;
        break;
      end
    end
    chk("finish_within_budget", int'(cyc >= 0), 1);
  endtask

  typedef struct {
    logic [3:0] c0x, c0y, c1x, c1y;
    bit         occ0;
    logic [3:0] fx, fy;
    int         lfsr;
    int         lat;
    int         nq;
  } vec_t;

  vec_t vt [6];
  int   cyc;

  initial begin
    vt[0] = '{4'd3,  4'd7,  4'd0, 4'd0, 1'b0, 4'd3, 4'd7, 1, 4, 1};
    vt[1] = '{4'd3,  4'd7,  4'd5, 4'd2, 1'b1, 4'd5, 4'd2, 2, 7, 2};
    vt[2] = '{4'd12, 4'd4,  4'd6, 4'd6, 1'b0, 4'd6, 4'd6, 2, 5, 1};
    vt[3] = '{4'd2,  4'd15, 4'd9, 4'd9, 1'b0, 4'd9, 4'd9, 2, 5, 1};
    vt[4] = '{4'd9,  4'd0,  4'd1, 4'd1, 1'b0, 4'd9, 4'd0, 1, 4, 1};
    vt[5] = '{4'd10, 4'd3,  4'd0, 4'd9, 1'b0, 4'd0, 4'd9, 2, 5, 1};

    reset      = 1'b1;
    spawn_req  = 1'b0;
    clear_food = 1'b0;
    mon_clr    = 1'b1;
    set_board(1'b0);
    set_rnd(4'd0, 4'd0);
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    mon_clr = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_lfsr_step",   int'(lfsr_step),   0);
    chk("rst_query_valid", int'(query_valid), 0);
    chk("rst_query_x",     int'(query_x),     0);
    chk("rst_query_y",     int'(query_y),     0);
    chk("rst_food_x",      int'(food_x),      0);
    chk("rst_food_y",      int'(food_y),      0);
    chk("rst_food_valid",  int'(food_valid),  0);
    chk("rst_busy",        int'(busy),        0);
    chk("rst_done",        int'(done),        0);
    chk("rst_fail",        int'(fail),        0);

    // Table: single placements through the random path.
    for (int i = 0; i < 6; i++) begin
      set_board(1'b0);
      if (vt[i].occ0) occ_map[vt[i].c0x][vt[i].c0y] = 1'b1;
      set_rnd(vt[i].c1x, vt[i].c1y);
      rnd_xs[0] = 4'd8;
      rnd_ys[0] = 4'd8;
      rnd_xs[1] = vt[i].c0x;
      rnd_ys[1] = vt[i].c0y;
      clr_mon();
      if (i == 0) chk("vec_food_valid_before", int'(food_valid), 0);
      spawn_req = 1'b1;
      #1;
      chk("vec_lfsr_on_spawn", int'(lfsr_step), 1);
      chk("vec_busy_idle", int'(busy), 0);
      wait_end(60, cyc);
      chk("vec_latency",    cyc,                vt[i].lat);
      chk("vec_done",       int'(done),         1);
      chk("vec_food_valid", int'(food_valid),   1);
      chk("vec_food_x",     int'(food_x),       int'(vt[i].fx));
      chk("vec_food_y",     int'(food_y),       int'(vt[i].fy));
      @(negedge clk);
      #1;
      chk("vec_done_pulse", int'(done),  0);
      chk("vec_busy_after", int'(busy),  0);
      chk("vec_lfsr_cnt",   lfsr_cnt,    vt[i].lfsr);
      chk("vec_query_n",    log_n,       vt[i].nq);
      chk("vec_qv_cycles",  qv_cycles,   2 * vt[i].nq);
      chk("vec_done_cnt",   done_cnt,    1);
      chk("vec_last_qx",    int'(log_x[(log_n - 1) & 255]), int'(vt[i].fx));
      chk("vec_last_qy",    int'(log_y[(log_n - 1) & 255]), int'(vt[i].fy));
    end

    // Random tries exhausted; only (4,1) free, found by scan.
    set_board(1'b1);
    occ_map[4][1] = 1'b0;
    set_rnd(4'd5, 4'd5);
    clr_mon();
    spawn_req = 1'b1;
    wait_end(600, cyc);
    chk("scan_latency", cyc,               55);
    chk("scan_done",    int'(done),        1);
    chk("scan_food_x",  int'(food_x),      4);
    chk("scan_food_y",  int'(food_y),      1);
    @(negedge clk);
    #1;
    chk("scan_lfsr_cnt", lfsr_cnt, 8);
    chk("scan_query_n",  log_n,    23);
    for (int j = 0; j < 15; j++) begin
      chk("scan_order_x", int'(log_x[8 + j]), j % 10);
      chk("scan_order_y", int'(log_y[8 + j]), j / 10);
    end

    // Full board: scan covers every cell then fails; prior food is kept.
    set_board(1'b1);
    clr_mon();
    spawn_req = 1'b1;
    wait_end(1000, cyc);
    chk("full_latency",    cyc,              225);
    chk("full_fail",       int'(fail),       1);
    chk("full_done",       int'(done),       0);
    chk("full_food_valid", int'(food_valid), 1);
    chk("full_food_x",     int'(food_x),     4);
    chk("full_food_y",     int'(food_y),     1);
    @(negedge clk);
    #1;
    chk("full_fail_pulse", int'(fail), 0);
    chk("full_busy",       int'(busy), 0);
    chk("full_fail_cnt",   fail_cnt,   1);
    chk("full_done_cnt",   done_cnt,   0);
    chk("full_query_n",    log_n,      108);
    chk("full_last_qx",    int'(log_x[107]), 9);
    chk("full_last_qy",    int'(log_y[107]), 9);

    // Reset during QUERY aborts without a done pulse.
    set_board(1'b0);
    set_rnd(4'd2, 4'd3);
    clr_mon();
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rq_query_valid", int'(query_valid), 1);
    chk("rq_query_x",     int'(query_x),     2);
    reset = 1'b1;
    #1;
    chk("rq_busy_now",  int'(busy),        0);
    chk("rq_qv_now",    int'(query_valid), 0);
    chk("rq_done_now",  int'(done),        0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("rq_done_cnt",   done_cnt,         0);
    chk("rq_food_valid", int'(food_valid), 0);
    chk("rq_busy",       int'(busy),       0);

    // clear_food in the PLACE cycle loses to placement; later it clears.
    set_rnd(4'd3, 4'd7);
    clr_mon();
    spawn_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      spawn_req = 1'b0;
    end
    @(negedge clk);
    clear_food = 1'b1;
    #1;
    chk("cf_place_done", int'(done), 1);
    @(negedge clk);
    clear_food = 1'b0;
    #1;
    chk("cf_food_valid_kept", int'(food_valid), 1);
    chk("cf_food_x",          int'(food_x),     3);
    chk("cf_food_y",          int'(food_y),     7);
    @(negedge clk);
    clear_food = 1'b1;
    @(negedge clk);
    clear_food = 1'b0;
    #1;
    chk("cf_food_valid_cleared", int'(food_valid), 0);
    chk("cf_food_x_held",        int'(food_x),     3);
    chk("cf_food_y_held",        int'(food_y),     7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
